axi4lite_master: RTL
====================

Name: axi4lite_master

Overview:
- AXI4-Lite initiator that turns a simple single-outstanding command/response port into AXI4-Lite write and read transactions.
- Drives the master side of the team's AXI4-Lite interface (AW/W/B/AR/R channels).
- Used as the RTL stimulus engine in front of the register slave, and as a reusable bus master in SoC glue.
- Exactly one transaction in flight at a time.

Parameters:
- ADDR_WIDTH, 4, address bus width in bits
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8

Ports:
- aclk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block accepts a command
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdata  input  DATA_WIDTH  write data; ignored for reads
- cmd_wstrb  input  DATA_WIDTH/8  write byte strobes; ignored for reads
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed
- rsp_write  output  1  echo of cmd_write for this response
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes
- rsp_resp  output  2  BRESP or RRESP as returned by the slave
- AWADDR/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in; BRESP/BVALID in, BREADY out; ARADDR/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out. Widths follow ADDR_WIDTH/DATA_WIDTH; BRESP/RRESP are 2 bits.
- err_count  output  16  only with AXIL_MST_ERRCNT_EN

Behaviour:
- One clock (aclk); reset is asynchronous and active-high (rst).
- All outputs registered.
- Reset values: all VALID/READY outputs 0, cmd_ready 0, rsp_valid 0, all payload outputs 0, state IDLE.
- cmd_ready rises on the first edge after rst deasserts.
- Reset asserted mid-transaction: outputs return to reset values immediately and the in-flight command is discarded.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready:
  - latch cmd_* fields and drop cmd_ready;
  - write: next state WR_REQ with AWVALID=1 and WVALID=1 in the same cycle;
  - read: next state RD_REQ with ARVALID=1.
- WR_REQ: AW and W complete independently.
  - AWVALID drops the cycle after AWVALID&&AWREADY; WVALID drops the cycle after WVALID&&WREADY.
  - Both handshakes in the same cycle are allowed.
  - Payload is held stable while the corresponding VALID is high.
  - Once both have completed, go to WR_RESP with BREADY=1.
- WR_RESP: on BVALID&&BREADY:
  - capture BRESP into rsp_resp, set rsp_rdata=0, rsp_write=1;
  - drop BREADY; rsp_valid=1 the next cycle; state RSP.
- RD_REQ: on ARVALID&&ARREADY, drop ARVALID, set RREADY=1, go to RD_DATA.
- RD_DATA: on RVALID&&RREADY:
  - capture RDATA and RRESP, set rsp_write=0;
  - drop RREADY; rsp_valid=1 the next cycle; state RSP.
- RSP: rsp_valid and payload held until rsp_ready. On rsp_valid&&rsp_ready, drop rsp_valid and return to IDLE; cmd_ready=1 the next cycle.
- Zero-wait slave latency:
  - cmd accept at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2, rsp_valid at cycle 3;
  - reads follow the same timing: AR at 1, R at 2, rsp at 3.
- No back-to-back overlap: the next command is accepted at the earliest the cycle after response consumption.
- Addresses and strobes pass through unmodified: no alignment; cmd_wstrb=0 is still issued.
- BVALID/RVALID arriving while the matching READY is low are ignored; no timeout.
- BRESP/RRESP values other than OKAY are reported as-is; no retry.

Optional Feature:
- Macro AXIL_MST_ERRCNT_EN.
- Defined: adds output err_count[15:0], reset to 0.
  - Increments by 1 on each B or R handshake whose response is not 2'b00.
  - Saturates at 16'hFFFF.
  - Cleared only by rst.
- Undefined: err_count port and its logic are absent; behaviour otherwise identical.

Test Plan:
- Write addr=4'h4, wdata=32'hDEADBEEF, wstrb=4'hF, zero-wait slave -> AWADDR=4'h4 and WDATA=32'hDEADBEEF seen at cycle 1; rsp_valid at cycle 3 with rsp_write=1, rsp_resp=2'b00, rsp_rdata=0.
- Write with WREADY delayed 3 cycles after AWREADY -> AWVALID low after its handshake; WVALID held with WDATA stable until WREADY; BREADY rises only after both handshakes.
- Read addr=4'h8 with slave returning RDATA=32'h12345678, RRESP=2'b10 -> rsp_rdata=32'h12345678, rsp_resp=2'b10, rsp_write=0; err_count=1 when AXIL_MST_ERRCNT_EN is defined.
- rsp_ready held low 5 cycles -> rsp_valid and payload stable for all 5 cycles, cmd_ready stays 0; new cmd accepted the cycle after rsp_ready.
- rst asserted while in WR_REQ with AWVALID=1 -> AWVALID, WVALID and cmd_ready go 0 asynchronously; after release, cmd_ready=1 and a fresh read completes normally.
- With AXIL_MST_ERRCNT_EN defined, err_count preloaded to 16'hFFFE followed by 3 SLVERR responses -> err_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/axi4lite_master.sv
// AXI4-Lite initiator: one command/response transaction at a time onto AW/W/B/AR/R.
// Define AXIL_MST_ERRCNT_EN to add a saturating err_count of non-OKAY responses.
module axi4lite_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready
`ifdef AXIL_MST_ERRCNT_EN
    ,
    output logic [15:0]             err_count
`endif
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                    arvalid_q, arvalid_d, rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
`ifdef AXIL_MST_ERRCNT_EN
    logic [15:0]             err_count_q, err_count_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
`ifdef AXIL_MST_ERRCNT_EN
        err_count_d = err_count_q;
`endif
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently; B is only opened once both are done.
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = bresp;
                    rsp_rdata_d = '0;
                    rsp_write_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
`ifdef AXIL_MST_ERRCNT_EN
                    if (bresp != 2'b00 && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
`endif
                end
            end
            RD_REQ: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = rresp;
                    rsp_rdata_d = rdata;
                    rsp_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
`ifdef AXIL_MST_ERRCNT_EN
                    if (rresp != 2'b00 && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
`endif
                end
            end
            RSP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
`ifdef AXIL_MST_ERRCNT_EN
            err_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
`ifdef AXIL_MST_ERRCNT_EN
            err_count_q <= err_count_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign awaddr    = awaddr_q;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign araddr    = araddr_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
`ifdef AXIL_MST_ERRCNT_EN
    assign err_count = err_count_q;
`endif

endmodule
